// File: rtl/rr_burst_arb_if.sv
// Requester/engine bundle for rr_burst_arb; signal directions are named from the arbiter side.
interface rr_burst_arb_if #(
  parameter int NREQ = 4,
  parameter int LENW = 4,
  parameter int IDW  = 2
) ();
  logic [NREQ-1:0]      req_i;
  logic [NREQ*LENW-1:0] len_i;
  logic [NREQ-1:0]      gnt_o;
  logic                 do_o;
  logic [LENW-1:0]      beat_cnt_o;
  logic                 done_o;
  logic [IDW-1:0]       done_id_o;
  logic                 busy_o;

  modport master (
    output req_i, len_i,
    input  gnt_o, do_o, beat_cnt_o, done_o, done_id_o, busy_o
  );

  modport slave (
    input  req_i, len_i,
    output gnt_o, do_o, beat_cnt_o, done_o, done_id_o, busy_o
  );
endinterface

// File: rtl/rr_burst_arb.sv
// Non-preemptive round-robin arbiter that runs one winner's burst on a shared run/last engine.
// Define ARB_FIXED_PRIO_EN to replace round robin with fixed lowest-index-wins priority.
module rr_burst_arb #(
  parameter int NREQ = 4,
  parameter int LENW = 4,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_burst_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q;
  logic [LENW-1:0] rem_q;
  logic [LENW-1:0] beat_cnt_q;
  logic [IDW-1:0]  cur_id_q;
  logic [IDW-1:0]  done_id_q;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [LENW-1:0] win_len;
  logic [LENW-1:0] eff_len;

`ifdef ARB_FIXED_PRIO_EN
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_i[k]) begin
        win_found = 1'b1;
        win_idx   = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0]    ptr_q;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;

  // Rotate so the scan always starts at bit 0; the lowest set bit of req_rot is the winner's offset from ptr.
  always_comb begin
    req_dbl   = {bus.req_i, bus.req_i} >> ptr_q;
    req_rot   = req_dbl[NREQ-1:0];
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == LAST) begin
      ptr_q <= (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
    end
  end
`endif

  always_comb begin
    win_len = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == win_idx) win_len = bus.len_i[k*LENW +: LENW];
    end
    eff_len = (win_len == '0) ? LENW'(1) : win_len;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = win_found ? RUN : IDLE;
      RUN:     state_d = (rem_q == LENW'(1)) ? LAST : RUN;
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    bus.do_o   = 1'b0;
    bus.done_o = 1'b0;
    bus.busy_o = 1'b0;
    case (state_q)
      RUN: begin
        bus.do_o   = 1'b1;
        bus.busy_o = 1'b1;
      end
      LAST: begin
        bus.done_o = 1'b1;
        bus.busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Burst datapath; len is captured only at grant, so later changes cannot affect the running burst.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      rem_q      <= '0;
      beat_cnt_q <= '0;
      cur_id_q   <= '0;
      done_id_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_q      <= NREQ'(1) << win_idx;
            rem_q      <= eff_len;
            beat_cnt_q <= '0;
            cur_id_q   <= win_idx;
          end
        end
        RUN: begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == LENW'(1)) begin
            beat_cnt_q <= '0;
            done_id_q  <= cur_id_q;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        LAST: begin
          gnt_q      <= '0;
          beat_cnt_q <= '0;
        end
        default: begin
          gnt_q      <= '0;
          rem_q      <= '0;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.beat_cnt_o = beat_cnt_q;
  assign bus.done_id_o  = done_id_q;

endmodule

// File: tb/tb_rr_burst_arb.sv
// Directed self-checking bench for rr_burst_arb; expected ids follow the build's arbitration mode.
module tb_rr_burst_arb;

  localparam int NREQ = 4;
  localparam int LENW = 4;
  localparam int IDW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  rr_burst_arb_if #(.NREQ(NREQ), .LENW(LENW), .IDW(IDW)) bus ();

  rr_burst_arb #(.NREQ(NREQ), .LENW(LENW), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Assert reset at a falling edge, check reset values, release at the next falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    bus.req_i  = '0;
    bus.len_i  = '0;
    #1;
    check("rst_gnt",     32'(bus.gnt_o),      32'h0);
    check("rst_do",      32'(bus.do_o),       32'h0);
    check("rst_beat",    32'(bus.beat_cnt_o), 32'h0);
    check("rst_done",    32'(bus.done_o),     32'h0);
    check("rst_done_id", 32'(bus.done_id_o),  32'h0);
    check("rst_busy",    32'(bus.busy_o),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called one falling edge before the grant edge; walks RUN x l, LAST, IDLE.
  // At RUN cycle chg_at (1-based, 0 = never) req/len are overwritten.
  task automatic expect_burst(input int id, input int l, input int chg_at,
                              input logic [3:0] req_after, input logic [15:0] len_after,
                              input string tag);
    for (int k = 0; k < l; k++) begin
      @(negedge clk);
      check({tag, "_gnt"},  32'(bus.gnt_o),      32'(1 << id));
      check({tag, "_do"},   32'(bus.do_o),       32'h1);
      check({tag, "_busy"}, 32'(bus.busy_o),     32'h1);
      check({tag, "_beat"}, 32'(bus.beat_cnt_o), 32'(k));
      check({tag, "_nodone"}, 32'(bus.done_o),   32'h0);
      if (k + 1 == chg_at) begin
        bus.req_i = req_after;
        bus.len_i = len_after;
      end
    end
    @(negedge clk);
    check({tag, "_last_do"},   32'(bus.do_o),       32'h0);
    check({tag, "_done"},      32'(bus.done_o),     32'h1);
    check({tag, "_done_id"},   32'(bus.done_id_o),  32'(id));
    check({tag, "_last_busy"}, 32'(bus.busy_o),     32'h1);
    check({tag, "_last_beat"}, 32'(bus.beat_cnt_o), 32'h0);
    @(negedge clk);
    check({tag, "_idle_do"},   32'(bus.do_o),      32'h0);
    check({tag, "_idle_done"}, 32'(bus.done_o),    32'h0);
    check({tag, "_idle_busy"}, 32'(bus.busy_o),    32'h0);
    check({tag, "_idle_gnt"},  32'(bus.gnt_o),     32'h0);
    check({tag, "_held_id"},   32'(bus.done_id_o), 32'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t2_ids[4];
    int t3_ids[5];
`ifdef ARB_FIXED_PRIO_EN
    t2_ids = '{0, 0, 0, 0};
    t3_ids = '{0, 0, 0, 0, 0};
`else
    t2_ids = '{0, 2, 0, 2};
    t3_ids = '{0, 1, 2, 3, 0};
`endif
    bus.req_i = '0;
    bus.len_i = '0;

    // Single burst from requester 1, length 3; requester drops req on seeing gnt.
    do_reset();
    bus.req_i = 4'b0010;
    bus.len_i = 16'h0030;
    expect_burst(1, 3, 1, 4'b0000, 16'h0030, "t1");
    @(negedge clk);
    check("t1_busy2", 32'(bus.busy_o), 32'h0);

    // Two requesters held high, length 1 each.
    do_reset();
    bus.req_i = 4'b0101;
    bus.len_i = 16'h0101;
    for (int i = 0; i < 4; i++) expect_burst(t2_ids[i], 1, 0, 4'b0101, 16'h0101, "t2");

    // All requesters held high, length 2 each.
    do_reset();
    bus.req_i = 4'b1111;
    bus.len_i = 16'h2222;
    for (int i = 0; i < 5; i++) expect_burst(t3_ids[i], 2, 0, 4'b1111, 16'h2222, "t3");

    // Zero length field counts as one beat.
    do_reset();
    bus.req_i = 4'b1000;
    bus.len_i = 16'h0000;
    expect_burst(3, 1, 1, 4'b0000, 16'h0000, "t4");

    // Request withdrawn before any clock edge samples it.
    do_reset();
    bus.req_i = 4'b0100;
    bus.len_i = 16'h0300;
    #2;
    bus.req_i = 4'b0000;
    @(negedge clk);
    check("t_drop_busy", 32'(bus.busy_o), 32'h0);
    check("t_drop_gnt",  32'(bus.gnt_o),  32'h0);
    @(negedge clk);
    check("t_drop_do",   32'(bus.do_o),   32'h0);

    // Maximum length; req dropped and len zeroed on the 2nd RUN cycle.
    do_reset();
    bus.req_i = 4'b0001;
    bus.len_i = 16'h000F;
    expect_burst(0, 15, 2, 4'b0000, 16'h0000, "t5");

    // Asynchronous reset in the middle of a burst from requester 2.
    do_reset();
    bus.req_i = 4'b0100;
    bus.len_i = 16'h2502;
    @(negedge clk);
    check("t6_run_gnt", 32'(bus.gnt_o), 32'h4);
    check("t6_run_do",  32'(bus.do_o),  32'h1);
    bus.req_i = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_gnt",  32'(bus.gnt_o),      32'h0);
    check("t6_async_do",   32'(bus.do_o),       32'h0);
    check("t6_async_busy", 32'(bus.busy_o),     32'h0);
    check("t6_async_beat", 32'(bus.beat_cnt_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_done", 32'(bus.done_o), 32'h0);
      check("t6_rst_busy", 32'(bus.busy_o), 32'h0);
    end
    rst_n     = 1'b1;
    bus.req_i = 4'b1001;
    // Pointer restarts at 0, so requester 0 wins before requester 3.
    expect_burst(0, 2, 1, 4'b1000, 16'h2502, "t6a");
    expect_burst(3, 2, 1, 4'b0000, 16'h2502, "t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
